// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issuing side of the ULA interface. Accepts one 32-bit instruction per
//   handshake, reads operands from a synchronous register file, drives the
//   ULA operands for one cycle, captures Resultado/Zero, then retires with a
//   write-back strobe or a branch decision.
//   Sequence: IDLE -> READ -> EXEC -> RETIRE -> IDLE.
//
// Parameters
//   IMM_SIGNED : 1 = imm16 sign-extended onto Dados_2, 0 = zero-extended
//   WB_R0_EN   : 1 = write-back to register 0 allowed, 0 = suppressed
//
// Configuration macro
//   ALU_DIVZERO_TRAP_EN : opcode 0 / funct 3 with Dados_2 == 0 raises Trap
//                         in RETIRE and suppresses the write-back.
//                         Undefined: Trap is tied 0.
//
// Ports
//   clock, reset          clock; asynchronous active-low reset
//   Instr_valid/Instr     instruction offer; Instr_ready high only in IDLE
//   Reg_addr_1/2          rs/rt read addresses of the latched instruction
//   Reg_data_1/2          register data, valid one cycle after the address
//   Opcode/funct/Dados_*  ULA inputs, non-zero only during EXEC
//   Resultado/Zero        ULA result, captured at the end of EXEC
//   Wb_en/Wb_addr/Wb_data write-back strobe, destination, captured result
//   Branch_taken/_target  branch decision pulse and branch immediate
//   Done                  retirement pulse
//   Trap                  divide-by-zero pulse
module alu_issue_ctrl #(
  parameter int unsigned IMM_SIGNED = 1,
  parameter int unsigned WB_R0_EN   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Instr_valid,
  input  logic [31:0] Instr,
  output logic        Instr_ready,
  output logic [4:0]  Reg_addr_1,
  output logic [4:0]  Reg_addr_2,
  input  logic [31:0] Reg_data_1,
  input  logic [31:0] Reg_data_2,
  output logic [5:0]  Opcode,
  output logic [5:0]  funct,
  output logic [31:0] Dados_1,
  output logic [31:0] Dados_2,
  input  logic [31:0] Resultado,
  input  logic        Zero,
  output logic        Wb_en,
  output logic [4:0]  Wb_addr,
  output logic [31:0] Wb_data,
  output logic        Branch_taken,
  output logic [15:0] Branch_target,
  output logic        Done,
  output logic        Trap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_RETIRE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_addr_q;
  logic [15:0] br_target_q;
  logic        wb_pend_q;
  logic        br_pend_q;
  logic        zero_q;
  logic        trap_q;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic        use_imm;
  logic        wb_rd;
  logic        wb_rt;
  logic        is_branch;
  logic [4:0]  wb_dest;
  logic        wb_allowed;
  logic [31:0] operand_b;
  logic        in_exec;
  logic        in_retire;
  logic        accept;
  logic        trap_det;

  // Instruction decode from the latched word
  always_comb begin
    op        = instr_q[31:26];
    fn        = instr_q[5:0];
    imm       = instr_q[15:0];
    use_imm   = 1'b0;
    wb_rd     = 1'b0;
    wb_rt     = 1'b0;
    is_branch = 1'b0;
    case (op)
      6'd2, 6'd20:                   begin use_imm = 1'b1; wb_rt = 1'b1; end
      6'd5:                          begin use_imm = 1'b1; is_branch = 1'b1; end
      6'd6, 6'd7, 6'd8:              use_imm = 1'b1;
      6'd10, 6'd11, 6'd19:           is_branch = 1'b1;
      6'd0, 6'd1, 6'd3, 6'd4, 6'd13,
      6'd15, 6'd16, 6'd17, 6'd18:    wb_rd = 1'b1;
      default:                       ;
    endcase
  end

  always_comb begin
    if (IMM_SIGNED != 0) imm_ext = {{16{imm[15]}}, imm};
    else                 imm_ext = {16'h0000, imm};
  end

  assign wb_dest    = wb_rt ? instr_q[20:16] : instr_q[15:11];
  assign wb_allowed = (wb_rd || wb_rt) && ((WB_R0_EN != 0) || (wb_dest != '0));
  assign operand_b  = use_imm ? imm_ext : Reg_data_2;

  assign in_exec     = (state_q == S_EXEC);
  assign in_retire   = (state_q == S_RETIRE);
  assign Instr_ready = (state_q == S_IDLE);
  assign accept      = Instr_valid && Instr_ready;

  assign Reg_addr_1 = instr_q[25:21];
  assign Reg_addr_2 = instr_q[20:16];

  // ULA inputs are forced to zero outside EXEC
  assign Opcode  = in_exec ? op         : '0;
  assign funct   = in_exec ? fn         : '0;
  assign Dados_1 = in_exec ? Reg_data_1 : '0;
  assign Dados_2 = in_exec ? operand_b  : '0;

`ifdef ALU_DIVZERO_TRAP_EN
  assign trap_det = (op == 6'd0) && (fn == 6'd3) && (operand_b == '0);
`else
  assign trap_det = 1'b0;
`endif

  // Retirement pulses are decoded from the state so an asynchronous reset
  // removes them in the same instant.
  assign Done          = in_retire;
  assign Wb_en         = in_retire && wb_pend_q && !trap_q;
  assign Branch_taken  = in_retire && br_pend_q && zero_q;
  assign Trap          = in_retire && trap_q;
  assign Wb_addr       = wb_addr_q;
  assign Wb_data       = wb_data_q;
  assign Branch_target = br_target_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_READ;
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = S_RETIRE;
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q     <= '0;
      wb_data_q   <= '0;
      wb_addr_q   <= '0;
      br_target_q <= '0;
      wb_pend_q   <= 1'b0;
      br_pend_q   <= 1'b0;
      zero_q      <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      if (accept) instr_q <= Instr;
      if (in_exec) begin
        // A trapping divide leaves the previous result visible
        if (!trap_det) wb_data_q <= Resultado;
        zero_q    <= Zero;
        wb_addr_q <= wb_dest;
        wb_pend_q <= wb_allowed;
        br_pend_q <= is_branch;
        trap_q    <= trap_det;
        if (is_branch) br_target_q <= imm;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: table-driven instruction vectors plus
// hand-written back-to-back and mid-instruction reset sequences. Two
// instances: dut (IMM_SIGNED=1, WB_R0_EN=0) and dut_u (IMM_SIGNED=0,
// WB_R0_EN=1). The ULA and register file are modelled in the bench.
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        Instr_valid = 1'b0;
  logic [31:0] Instr = '0;
  logic [31:0] Reg_data_1 = '0;
  logic [31:0] Reg_data_2 = '0;

  logic        Instr_ready, Wb_en, Branch_taken, Done, Trap, Zero;
  logic [4:0]  Reg_addr_1, Reg_addr_2, Wb_addr;
  logic [5:0]  Opcode, funct;
  logic [31:0] Dados_1, Dados_2, Resultado, Wb_data;
  logic [15:0] Branch_target;

  logic        Instr_ready_u, Wb_en_u, Branch_taken_u, Done_u, Trap_u, Zero_u;
  logic [4:0]  Reg_addr_1_u, Reg_addr_2_u, Wb_addr_u;
  logic [5:0]  Opcode_u, funct_u;
  logic [31:0] Dados_1_u, Dados_2_u, Resultado_u, Wb_data_u;
  logic [15:0] Branch_target_u;

  logic [31:0] rf [32];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  alu_issue_ctrl #(.IMM_SIGNED(1), .WB_R0_EN(0)) dut (
    .clock(clock), .reset(reset), .Instr_valid(Instr_valid), .Instr(Instr),
    .Instr_ready(Instr_ready), .Reg_addr_1(Reg_addr_1), .Reg_addr_2(Reg_addr_2),
    .Reg_data_1(Reg_data_1), .Reg_data_2(Reg_data_2), .Opcode(Opcode), .funct(funct),
    .Dados_1(Dados_1), .Dados_2(Dados_2), .Resultado(Resultado), .Zero(Zero),
    .Wb_en(Wb_en), .Wb_addr(Wb_addr), .Wb_data(Wb_data), .Branch_taken(Branch_taken),
    .Branch_target(Branch_target), .Done(Done), .Trap(Trap)
  );

  alu_issue_ctrl #(.IMM_SIGNED(0), .WB_R0_EN(1)) dut_u (
    .clock(clock), .reset(reset), .Instr_valid(Instr_valid), .Instr(Instr),
    .Instr_ready(Instr_ready_u), .Reg_addr_1(Reg_addr_1_u), .Reg_addr_2(Reg_addr_2_u),
    .Reg_data_1(Reg_data_1), .Reg_data_2(Reg_data_2), .Opcode(Opcode_u), .funct(funct_u),
    .Dados_1(Dados_1_u), .Dados_2(Dados_2_u), .Resultado(Resultado_u), .Zero(Zero_u),
    .Wb_en(Wb_en_u), .Wb_addr(Wb_addr_u), .Wb_data(Wb_data_u), .Branch_taken(Branch_taken_u),
    .Branch_target(Branch_target_u), .Done(Done_u), .Trap(Trap_u)
  );

  // Synchronous-read register file (both instances present identical addresses)
  always @(posedge clock) begin
    Reg_data_1 <= rf[Reg_addr_1];
    Reg_data_2 <= rf[Reg_addr_2];
  end

  function automatic logic [31:0] ula(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      6'd0: case (fn)
              6'd0: r = a + b;
              6'd1: r = a - b;
              6'd2: r = a & b;
              6'd3: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
              6'd4: r = a | b;
              6'd5: r = a ^ b;
              default: r = 32'd0;
            endcase
      6'd1: case (fn)
              6'd0: r = a << b[4:0];
              6'd1: r = a >> b[4:0];
              6'd2: r = a & ~b;
              6'd3: r = ~(a | b);
              default: r = 32'd0;
            endcase
      6'd5, 6'd10, 6'd11, 6'd19: r = a - b;
      6'd20: r = a | b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign Resultado   = ula(Opcode, funct, Dados_1, Dados_2);
  assign Zero        = (Resultado == 32'd0);
  assign Resultado_u = ula(Opcode_u, funct_u, Dados_1_u, Dados_2_u);
  assign Zero_u      = (Resultado_u == 32'd0);

  function automatic logic [31:0] r_type(input int unsigned op, input int unsigned rs,
                                         input int unsigned rt, input int unsigned rd,
                                         input int unsigned fn);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] i_type(input int unsigned op, input int unsigned rs,
                                         input int unsigned rt, input int unsigned imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        wb;
    logic [4:0]  addr;
    logic        chk_data;
    logic [31:0] data;
    logic        br;
    logic        taken;
    logic [15:0] target;
    logic        trap;
    logic        wb_u;
    logic [31:0] data_u;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clock);
    check($sformatf("v%0d.ready_idle", i), 32'(Instr_ready), 32'd1);
    Instr       = v.instr;
    Instr_valid = 1'b1;
    @(posedge clock);
    #1 Instr_valid = 1'b0;
    check($sformatf("v%0d.ready_busy", i), 32'(Instr_ready), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check($sformatf("v%0d.exec_opcode", i), 32'(Opcode), 32'(v.instr[31:26]));
    check($sformatf("v%0d.exec_dados1", i), Dados_1, rf[v.instr[25:21]]);
    @(posedge clock);
    @(negedge clock);
    check($sformatf("v%0d.done", i), 32'(Done), 32'd1);
    check($sformatf("v%0d.wb_en", i), 32'(Wb_en), 32'(v.wb));
    if (v.wb) check($sformatf("v%0d.wb_addr", i), 32'(Wb_addr), 32'(v.addr));
    if (v.chk_data) check($sformatf("v%0d.wb_data", i), Wb_data, v.data);
    check($sformatf("v%0d.br_taken", i), 32'(Branch_taken), 32'(v.taken));
    if (v.br) check($sformatf("v%0d.br_target", i), 32'(Branch_target), 32'(v.target));
    check($sformatf("v%0d.trap", i), 32'(Trap), 32'(v.trap));
    check($sformatf("v%0d.opcode_retire", i), 32'(Opcode), 32'd0);
    check($sformatf("v%0d.u_wb_en", i), 32'(Wb_en_u), 32'(v.wb_u));
    if (v.chk_data) check($sformatf("v%0d.u_wb_data", i), Wb_data_u, v.data_u);
    @(posedge clock);
  endtask

  initial begin
    logic [9:0] done_vec;
    logic       seen;

    for (int r = 0; r < 32; r++) rf[r] = '0;
    rf[1] = 32'd5;    rf[2] = 32'd7;    rf[5] = 32'h55;  rf[6] = 32'h55;
    rf[8] = 32'h56;   rf[9] = 32'd100;  rf[10] = 32'd10; rf[14] = 32'h40;

    //               instr                        wb    addr   chk  data           br    tk    target    trap  wb_u  data_u
    vecs[0]  = '{r_type(0, 1, 2, 3, 0),          1'b1, 5'd3,  1'b1, 32'd12,        1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd12};
    vecs[1]  = '{i_type(2, 10, 4, 16'hFFFF),     1'b1, 5'd4,  1'b1, 32'd9,         1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0001_0009};
    vecs[2]  = '{i_type(10, 5, 6, 16'h0040),     1'b0, 5'd0,  1'b1, 32'd0,         1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{i_type(10, 5, 8, 16'h0080),     1'b0, 5'd0,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 16'h0080, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[4]  = '{i_type(5, 14, 0, 16'h0040),     1'b0, 5'd0,  1'b1, 32'd0,         1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 32'd0};
    vecs[5]  = '{r_type(0, 1, 2, 12, 7),         1'b1, 5'd12, 1'b1, 32'd0,         1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd0};
    vecs[6]  = '{r_type(1, 1, 2, 13, 5),         1'b1, 5'd13, 1'b1, 32'd0,         1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd0};
    vecs[7]  = '{i_type(6, 1, 3, 16'h0003),      1'b0, 5'd0,  1'b1, 32'd8,         1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd8};
    vecs[8]  = '{r_type(63, 1, 2, 0, 0),         1'b0, 5'd0,  1'b1, 32'd12,        1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd12};
    vecs[9]  = '{r_type(0, 1, 2, 0, 0),          1'b0, 5'd0,  1'b1, 32'd12,        1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd12};
    vecs[10] = '{i_type(20, 1, 13, 16'h00F0),    1'b1, 5'd13, 1'b1, 32'h0000_00F5, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0000_00F5};
    vecs[11] = '{r_type(1, 1, 2, 7, 0),          1'b1, 5'd7,  1'b1, 32'd640,       1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd640};
`ifdef ALU_DIVZERO_TRAP_EN
    vecs[12] = '{r_type(0, 9, 0, 11, 3),         1'b0, 5'd0,  1'b1, 32'd640,       1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'd640};
`else
    vecs[12] = '{r_type(0, 9, 0, 11, 3),         1'b1, 5'd11, 1'b0, 32'd0,         1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd0};
`endif

    // Reset state
    #2;
    check("rst.ready", 32'(Instr_ready), 32'd1);
    check("rst.done", 32'(Done), 32'd0);
    check("rst.wb_en", 32'(Wb_en), 32'd0);
    check("rst.wb_data", Wb_data, 32'd0);
    check("rst.br_target", 32'(Branch_target), 32'd0);
    check("rst.trap", 32'(Trap), 32'd0);
    check("rst.dados2", Dados_2, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-to-back: valid held high across two instructions
    @(negedge clock);
    Instr       = r_type(0, 1, 2, 3, 0);
    Instr_valid = 1'b1;
    done_vec    = '0;
    for (int e = 0; e < 9; e++) begin
      @(posedge clock);
      #1;
      if (e == 0) Instr = i_type(2, 10, 4, 16'h0005);
      if (e == 4) Instr_valid = 1'b0;
      @(negedge clock);
      done_vec[e + 1] = Done;
      if (e == 2) check("b2b.first_wb_data", Wb_data, 32'd12);
      if (e == 3) check("b2b.ready_cycle4", 32'(Instr_ready), 32'd1);
      if (e == 6) begin
        check("b2b.second_wb_en", 32'(Wb_en), 32'd1);
        check("b2b.second_wb_addr", 32'(Wb_addr), 32'd4);
        check("b2b.second_wb_data", Wb_data, 32'd15);
      end
    end
    check("b2b.done_cycles", 32'(done_vec), 32'h088);

    // Reset asserted during EXEC aborts the instruction
    @(negedge clock);
    Instr       = r_type(0, 1, 2, 3, 0);
    Instr_valid = 1'b1;
    @(posedge clock);
    #1 Instr_valid = 1'b0;
    @(posedge clock);
    #2;
    check("rexec.dados1_before", Dados_1, 32'd5);
    reset = 1'b0;
    #1;
    check("rexec.ready", 32'(Instr_ready), 32'd1);
    check("rexec.dados1", Dados_1, 32'd0);
    check("rexec.opcode", 32'(Opcode), 32'd0);
    check("rexec.wb_data", Wb_data, 32'd0);
    check("rexec.reg_addr1", 32'(Reg_addr_1), 32'd0);
    check("rexec.done", 32'(Done), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      seen = seen | Done | Wb_en;
    end
    check("rexec.no_retire", 32'(seen), 32'd0);
    check("rexec.ready_after", 32'(Instr_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
